// File: rtl/count_share_sched.sv
// Round-robin scheduler sharing one up-counter among N requesters.
// Each grant bumps the count; granting stops at LIMIT until cleared.
module count_share_sched #(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 4,
  parameter int unsigned LIMIT = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         clr,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [W-1:0] count,
  output logic         full,
  output logic         valid
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {StRun, StFull} state_e;

  state_e          state;
  logic [PW-1:0]   ptr;
  logic            full_old;

  logic            found;
  logic [PW-1:0]   win;
  logic [PW-1:0]   ptr_nxt;
  logic [N-1:0]    win_onehot;
  logic [W-1:0]    count_inc;

  // Cyclic priority search starting at ptr.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      int unsigned j;
      j = (int'(ptr) + i) % N;
      if (!found && req[j]) begin
        found = 1'b1;
        win   = PW'(j);
      end
    end
  end

  always_comb begin
    win_onehot      = '0;
    win_onehot[win] = 1'b1;
    ptr_nxt         = (int'(win) == N - 1) ? '0 : win + 1'b1;
    count_inc       = count + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StRun;
      gnt      <= '0;
      count    <= '0;
      ptr      <= '0;
      full_old <= 1'b0;
    end else begin
      full_old <= full;
      if (clr) begin
        state <= StRun;
        gnt   <= '0;
        count <= '0;
      end else begin
        unique case (state)
          StRun: begin
            if (ena && found) begin
              gnt   <= win_onehot;
              ptr   <= ptr_nxt;
              count <= count_inc;
              if (count_inc == W'(LIMIT)) state <= StFull;
            end else begin
              gnt <= '0;
            end
          end
          StFull: gnt <= '0;
          default: begin
            state <= StRun;
            gnt   <= '0;
          end
        endcase
      end
    end
  end

  assign full = (state == StFull);

  // A non-zero grant is legal in FULL only on its first cycle.
  assign valid = ((gnt & (gnt - 1'b1)) == '0) &&
                 (count <= W'(LIMIT)) &&
                 !(full_old && full && (gnt != '0));

endmodule
